// File: rtl/sram_ctrl_pkg.sv
// Shared widths, types and sizing helpers for the 1rw1r SRAM request controller.
package sram_ctrl_pkg;

    localparam int SRAM_DATA_WIDTH = 8;
    localparam int SRAM_ADDR_WIDTH = 10;
    localparam int SRAM_NUM_WMASKS = 2;
    localparam int SRAM_RSP_DEPTH  = 4;

    typedef logic [SRAM_DATA_WIDTH-1:0] data_t;
    typedef logic [SRAM_ADDR_WIDTH-1:0] addr_t;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int SRAM_RSP_CNT_W = cnt_width(SRAM_RSP_DEPTH);

endpackage

// File: rtl/sram_rsp_fifo.sv
// Ordered response FIFO: wrapping read/write pointers plus an occupancy count.
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_push_ok = i_push && !w_full;
    assign w_pop_ok  = i_pop && o_valid;

    assign o_valid = (r_count != '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Upstream credit accounting guarantees this never fires.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(i_push && w_full));

endmodule

// File: rtl/sram_1rw1r_req_ctrl.sv
// Valid/ready front-end for the 1rw1r SRAM macro: port 0 writes, port 1 reads,
// read data returned in order through a credit-limited response FIFO.
module sram_1rw1r_req_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int NUM_WMASKS = SRAM_NUM_WMASKS,
    parameter int RSP_DEPTH  = SRAM_RSP_DEPTH
) (
    input  logic                  clk0,
    input  logic                  rst_n,

    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_WMASKS-1:0] wr_mask,

    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,

    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    localparam int              CNT_W      = cnt_width(RSP_DEPTH);
    localparam logic [CNT_W:0]  CREDIT_LIM = (CNT_W + 1)'(RSP_DEPTH);

    logic                  r_alive;
    logic                  r_a;
    logic                  r_b;
    logic                  r_csb0;
    logic                  r_web0;
    logic [NUM_WMASKS-1:0] r_wmask0;
    logic [ADDR_WIDTH-1:0] r_addr0;
    logic [DATA_WIDTH-1:0] r_din0;
    logic                  r_csb1;
    logic [ADDR_WIDTH-1:0] r_addr1;

    logic                  w_collision;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_pop;
    logic                  w_rsp_valid;
    logic [CNT_W-1:0]      w_fifo_count;
    logic [CNT_W:0]        w_inflight;

    // Every read in stage A, stage B or parked in the FIFO holds one credit.
    assign w_inflight  = {{CNT_W{1'b0}}, r_a} + {{CNT_W{1'b0}}, r_b} + {1'b0, w_fifo_count};

    // Same-address write and read: take the write now, push the read back a
    // cycle so it lands after the macro has committed the new data.
    assign w_collision = wr_valid && rd_valid && (wr_addr == rd_addr);

    assign wr_ready  = r_alive;
    assign rd_ready  = r_alive && (w_inflight < CREDIT_LIM) && !w_collision;
    assign w_wr_acc  = wr_valid && wr_ready;
    assign w_rd_acc  = rd_valid && rd_ready;

    assign rsp_valid = w_rsp_valid;
    assign w_pop     = w_rsp_valid && rsp_ready;

    assign sram_csb0   = r_csb0;
    assign sram_web0   = r_web0;
    assign sram_wmask0 = r_wmask0;
    assign sram_addr0  = r_addr0;
    assign sram_din0   = r_din0;
    assign sram_csb1   = r_csb1;
    assign sram_addr1  = r_addr1;

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_csb0   <= 1'b1;
            r_web0   <= 1'b1;
            r_wmask0 <= '0;
            r_addr0  <= '0;
            r_din0   <= '0;
        end else begin
            r_csb0 <= !w_wr_acc;
            r_web0 <= !w_wr_acc;
            if (w_wr_acc) begin
                r_wmask0 <= wr_mask;
                r_addr0  <= wr_addr;
                r_din0   <= wr_data;
            end
        end
    end

    // dout1 settles on the negedge after the macro samples, so B captures it
    // one full cycle after issue.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_csb1  <= 1'b1;
            r_addr1 <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
        end else begin
            r_csb1 <= !w_rd_acc;
            if (w_rd_acc) begin
                r_addr1 <= rd_addr;
            end
            r_a <= w_rd_acc;
            r_b <= r_a;
        end
    end

    sram_rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk0),
        .rst_n   (rst_n),
        .i_push  (r_b),
        .i_din   (sram_dout1),
        .i_pop   (w_pop),
        .o_dout  (rsp_data),
        .o_valid (w_rsp_valid),
        .o_count (w_fifo_count)
    );

endmodule
